adder_operand_sequencer: RTL and testbench
==========================================

// Module: adder_operand_sequencer
// PURPOSE
//  Upstream driver for the 4-bit state-machine adder. Buffers operand pairs (A,B) in a small FIFO.
//  Replays each pair on the adder's data/load_a/load_b pins and waits for the adder's ready flag.
//  Captures {carry,sum} and returns it on a valid/ready result port, with a timeout guard.
// PARAMETERS
//  FIFO_DEPTH  4   operand-pair FIFO entries; power of two, >=2
//  TIMEOUT     15  max cycles in WAIT_RDY before the op is aborted with an error; >=1
//  CNT_W       8   width of completed-operation counter ops_done
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      reset, asynchronous, active-low
//  in_valid    in   1      operand pair valid
//  in_ready    out  1      FIFO can accept a pair (= !full)
//  in_a        in   4      operand A
//  in_b        in   4      operand B
//  add_data    out  4      to adder data_in
//  add_load_a  out  1      to adder load_a
//  add_load_b  out  1      to adder load_b
//  add_sum     in   4      from adder sum
//  add_carry   in   1      from adder carry
//  add_ready   in   1      from adder ready flag
//  res_valid   out  1      result valid
//  res_ready   in   1      result consumer ready
//  res_sum     out  5      {carry,sum}
//  res_err     out  1      result is a timeout abort
//  err_sticky  out  1      set on any timeout, cleared only by reset
//  ops_done    out  CNT_W  successful ops, wraps modulo 2^CNT_W
//  busy        out  1      FSM not in IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, timer=0; all outputs 0 except in_ready=1.
//  FIFO: push on in_valid&&in_ready; pop only on the IDLE->ISSUE_A transition; order preserved.
//   At full, in_ready=0, even in a pop cycle (no bypass).
//  add_* outputs decode from the state and op registers only; there is no comb path from any input.
//   add_data=op_a in ISSUE_A, op_b in ISSUE_B, else 0.
//  FSM:
//   IDLE: FIFO non-empty && !add_ready -> pop into op_a/op_b, go ISSUE_A. Else stay.
//   ISSUE_A (1 cycle): add_load_a=1, add_load_b=0 -> ISSUE_B.
//   ISSUE_B (1 cycle): add_load_b=1, add_load_a=0 -> WAIT_RDY, timer<=0.
//   WAIT_RDY: both loads 0. Adder leaves RESULT on the next edge.
//    add_ready && slot free (!res_valid || res_ready): load res_sum={add_carry,add_sum}, res_err=0, res_valid=1, ops_done++, go IDLE.
//    add_ready && slot busy: hold={add_carry,add_sum}, go DELIVER.
//    !add_ready && timer==TIMEOUT-1: hold=0, err flag set, err_sticky=1, go DELIVER. Else timer++.
//   DELIVER: when slot free, load res_* from hold and err flag, res_valid=1, go IDLE.
//    ops_done++ only if err flag is clear.
//  Result port: res_valid drops on res_valid&&res_ready unless reloaded that cycle. res_* stable while valid&&!ready.
//  Latency: handshake in cycle 0 with empty FIFO, idle FSM and free slot -> res_valid=1 in cycle 5.
//  Throughput: one op per 4 cycles with res_ready=1.
//  Sum is 5-bit, no truncation: 0..30. ops_done wraps silently.
//  Reset mid-op asserts asynchronously. It discards the FIFO contents, the pending op and any undelivered result.
// TESTING
//  A=9,B=8, res_ready=1 -> add_load_a cycle 2, add_load_b cycle 3; res_sum=5'h11, res_err=0 in cycle 5; ops_done=1.
//  A=15,B=15 then A=0,B=0 back-to-back -> res_sum=5'h1E then 5'h00, issued 4 cycles apart, in order.
//  res_ready=0, push 6 pairs -> in_ready=0 once FIFO full and slot busy; release -> all 6 results, correct order, no loss.
//  add_ready tied 0, TIMEOUT=15 -> result in cycle 20 with res_err=1, res_sum=0; err_sticky=1; ops_done unchanged.
//  rst_n low during WAIT_RDY with 2 pairs queued -> all outputs at reset values the same cycle; no result appears after release.
//  CNT_W=2, 5 ops -> ops_done=1 (wrap); add_ready held 1 in IDLE -> no issue until it drops.

Source files
------------

// File: rtl/adder_operand_sequencer.sv
// -----------------------------------------------------------------------------
// adder_operand_sequencer
//
// Upstream driver for the 4-bit state-machine adder. Operand pairs (A,B) are
// queued in a small FIFO. Each pair is replayed on the adder pins (A with
// load_a, then B with load_b). The sequencer then waits for the adder's ready
// flag and returns {carry,sum} on a valid/ready result port. A timeout guard
// aborts an operation whose ready flag never arrives.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   in_valid/in_ready       operand-pair handshake (in_ready = FIFO not full)
//   in_a, in_b              4-bit operands
//   add_data, add_load_a,   adder drive pins, decoded from registers only
//   add_load_b
//   add_sum, add_carry,     adder result and ready flag
//   add_ready
//   res_valid/res_ready     result handshake
//   res_sum                 {carry,sum}, 0..30
//   res_err                 result is a timeout abort (res_sum = 0)
//   err_sticky              set on any timeout, cleared only by reset
//   ops_done                successful operations, wraps modulo 2^CNT_W
//   busy                    FSM not idle or FIFO non-empty
// -----------------------------------------------------------------------------
module adder_operand_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [3:0]       add_data,
    output logic             add_load_a,
    output logic             add_load_b,
    input  logic [3:0]       add_sum,
    input  logic             add_carry,
    input  logic             add_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_sum,
    output logic             res_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] ops_done,
    output logic             busy
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_A,
        S_ISSUE_B,
        S_WAIT_RDY,
        S_DELIVER
    } state_t;

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [3:0]          op_a, op_b;
    logic [4:0]          hold_sum;
    logic                hold_err;

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]   fifo_cnt;
    logic                fifo_full, fifo_empty;
    logic                push, pop;

    logic                slot_free;
    logic                res_load, res_load_err;
    logic [4:0]          res_load_sum;
    logic                hold_load, hold_load_err;
    logic [4:0]          hold_load_sum;
    logic                timer_clr, timer_inc, ops_inc, timeout_hit;

    assign fifo_full  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // No bypass: a full FIFO refuses a push even while it is being popped.
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign slot_free  = !res_valid || res_ready;
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        res_load      = 1'b0;
        res_load_sum  = 5'd0;
        res_load_err  = 1'b0;
        hold_load     = 1'b0;
        hold_load_sum = 5'd0;
        hold_load_err = 1'b0;
        timer_clr     = 1'b0;
        timer_inc     = 1'b0;
        ops_inc       = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                // A still-high ready flag means the adder has not returned
                // to its idle state yet; issuing now would be lost.
                if (!fifo_empty && !add_ready) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE_A;
                end
            end
            S_ISSUE_A: state_nxt = S_ISSUE_B;
            S_ISSUE_B: begin
                timer_clr = 1'b1;
                state_nxt = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (add_ready) begin
                    // The adder only shows its result for this one cycle,
                    // so capture it now even if the result slot is busy.
                    if (slot_free) begin
                        res_load     = 1'b1;
                        res_load_sum = {add_carry, add_sum};
                        ops_inc      = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        hold_load     = 1'b1;
                        hold_load_sum = {add_carry, add_sum};
                        state_nxt     = S_DELIVER;
                    end
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    hold_load     = 1'b1;
                    hold_load_err = 1'b1;
                    timeout_hit   = 1'b1;
                    state_nxt     = S_DELIVER;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_DELIVER: begin
                if (slot_free) begin
                    res_load     = 1'b1;
                    res_load_sum = hold_sum;
                    res_load_err = hold_err;
                    ops_inc      = !hold_err;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Adder pins depend only on state and operand registers
    always_comb begin
        add_load_a = (state == S_ISSUE_A);
        add_load_b = (state == S_ISSUE_B);
        case (state)
            S_ISSUE_A: add_data = op_a;
            S_ISSUE_B: add_data = op_b;
            default:   add_data = 4'd0;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            hold_err   <= 1'b0;
            res_valid  <= 1'b0;
            res_sum    <= 5'd0;
            res_err    <= 1'b0;
            err_sticky <= 1'b0;
            ops_done   <= '0;
        end else begin
            state <= state_nxt;
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + TMR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (hold_load) hold_err <= hold_load_err;
            if (res_load) begin
                res_valid <= 1'b1;
                res_sum   <= res_load_sum;
                res_err   <= res_load_err;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (timeout_hit) err_sticky <= 1'b1;
            if (ops_inc)     ops_done   <= ops_done + CNT_W'(1);
        end
    end

    // Data registers: contents are only meaningful behind the control state
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {in_a, in_b};
        if (pop) begin
            op_a <= fifo_mem[rd_ptr][7:4];
            op_b <= fifo_mem[rd_ptr][3:0];
        end
        if (hold_load) hold_sum <= hold_load_sum;
    end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a, in_b;
    logic [3:0]       add_data;
    logic             add_load_a, add_load_b;
    logic [3:0]       add_sum;
    logic             add_carry;
    logic             add_ready;
    logic             res_valid;
    logic             res_ready;
    logic [4:0]       res_sum;
    logic             res_err;
    logic             err_sticky;
    logic [CNT_W-1:0] ops_done;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q[$];   // {err, sum} in expected delivery order

    // Adder model: RESULT (ready=1) for one cycle right after load_b
    logic [3:0] ma = 4'd0, mb = 4'd0;
    logic       mrdy = 1'b0;
    int         rdy_mode = 0;   // 0 model, 1 force low, 2 force high

    always #5 clk = ~clk;

    adder_operand_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_data(add_data), .add_load_a(add_load_a), .add_load_b(add_load_b),
        .add_sum(add_sum), .add_carry(add_carry), .add_ready(add_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_err(res_err), .err_sticky(err_sticky), .ops_done(ops_done),
        .busy(busy)
    );

    always @(posedge clk) begin
        if (add_load_a) ma <= add_data;
        if (add_load_b) mb <= add_data;
        mrdy <= add_load_b;
    end

    always_comb begin
        {add_carry, add_sum} = {1'b0, ma} + {1'b0, mb};
        add_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : mrdy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard: every accepted result must match the next expected one
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) check_eq("res_unexpected", res_valid, 0);
            else check_eq("res_order", {res_err, res_sum}, exp_q.pop_front());
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        logic acc;
        int   n;
        in_valid = 1'b1; in_a = a; in_b = b;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) break;
            n++;
            if (n > 50) begin
                check_eq("push_timeout", acc, 1);
                break;
            end
        end
        if (acc) exp_q.push_back({1'b0, 5'(a) + 5'(b)});
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ops_done", ops_done, 0);
        check_eq("rst_err_sticky", err_sticky, 0);
        check_eq("rst_add_pins", {add_load_a, add_load_b, add_data}, 0);
        check_eq("rst_res_sum", {res_err, res_sum}, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // 9 + 8: load_a in cycle 2, load_b in cycle 3, result in cycle 5
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd8;          // cycle 0
        exp_q.push_back(6'h11);
        step(); in_valid = 1'b0;                             // cycle 1
        step(); @(negedge clk);                              // cycle 2
        check_eq("t1_issue_a", {add_load_a, add_load_b, add_data}, {1'b1, 1'b0, 4'd9});
        step(); @(negedge clk);                              // cycle 3
        check_eq("t1_issue_b", {add_load_a, add_load_b, add_data}, {1'b0, 1'b1, 4'd8});
        step(); @(negedge clk);                              // cycle 4
        check_eq("t1_not_yet", res_valid, 0);
        step(); @(negedge clk);                              // cycle 5
        check_eq("t1_valid", res_valid, 1);
        check_eq("t1_result", {res_err, res_sum}, 6'h11);
        check_eq("t1_ops_done", ops_done, 1);
        repeat (3) step();

        // 15+15 then 0+0 back-to-back, results 4 cycles apart
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;        // cycle 0
        exp_q.push_back(6'h1E);
        step(); in_a = 4'd0; in_b = 4'd0;                   // cycle 1
        exp_q.push_back(6'h00);
        step(); in_valid = 1'b0;                             // cycle 2
        repeat (3) step(); @(negedge clk);                   // cycle 5
        check_eq("t2_first", {res_valid, res_err, res_sum}, {1'b1, 6'h1E});
        repeat (3) step(); @(negedge clk);                   // cycle 8
        check_eq("t2_gap", res_valid, 0);
        step(); @(negedge clk);                              // cycle 9
        check_eq("t2_second", {res_valid, res_err, res_sum}, {1'b1, 6'h00});
        check_eq("t2_ops_done", ops_done, 3);
        repeat (3) step();

        // Backpressure: 6 pairs with the result port stalled
        res_ready = 1'b0;
        push(4'd1, 4'd2);  push(4'd7, 4'd7);  push(4'd15, 4'd1);
        push(4'd10, 4'd9); push(4'd12, 4'd5); push(4'd6, 4'd14);
        repeat (10) step();
        @(negedge clk);
        check_eq("t3_full", in_ready, 0);
        check_eq("t3_held", {res_valid, res_err, res_sum}, {1'b1, 6'h03});
        check_eq("t3_busy", busy, 1);
        step();
        res_ready = 1'b1;
        drain("t3_drain");
        repeat (3) step();
        check_eq("t3_ops_wrap", ops_done, 1);            // 9 ops mod 4

        // Timeout: adder never signals ready
        rdy_mode = 1;
        in_valid = 1'b1; in_a = 4'd4; in_b = 4'd3;          // cycle 0
        exp_q.push_back({1'b1, 5'd0});
        step(); in_valid = 1'b0;                             // cycle 1
        repeat (18) step(); @(negedge clk);                  // cycle 19
        check_eq("t4_not_yet", res_valid, 0);
        step(); @(negedge clk);                              // cycle 20
        check_eq("t4_result", {res_valid, res_err, res_sum}, {1'b1, 1'b1, 5'd0});
        check_eq("t4_sticky", err_sticky, 1);
        check_eq("t4_ops_same", ops_done, 1);
        step();
        rdy_mode = 0;
        repeat (3) step();

        // Reset during WAIT_RDY with two pairs still queued
        rdy_mode = 1;
        push(4'd2, 4'd2); push(4'd3, 4'd3); push(4'd5, 4'd5); // now cycle 3
        repeat (2) step();                                   // cycle 5, WAIT_RDY
        @(negedge clk);
        check_eq("t5_busy_before", busy, 1);
        step(); #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        rdy_mode = 0;
        check_eq("t5_rst_ctrl", {in_ready, res_valid, busy, err_sticky}, 4'b1000);
        check_eq("t5_rst_pins", {add_load_a, add_load_b, add_data}, 0);
        check_eq("t5_rst_res", {ops_done, res_err, res_sum}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
            step();
        end
        check_eq("t5_no_result", seen, 0);
        check_eq("t5_idle", busy, 0);

        // Counter wrap with CNT_W=2: 5 ops -> 1
        push(4'd2, 4'd3); push(4'd4, 4'd4); push(4'd9, 4'd9);
        push(4'd1, 4'd0); push(4'd15, 4'd14);
        drain("t6_drain");
        repeat (3) step();
        check_eq("t6_ops_wrap", ops_done, 1);

        // add_ready high in IDLE blocks issue until it drops
        rdy_mode = 2;
        push(4'd5, 4'd6);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (add_load_a) seen++;
            step();
        end
        check_eq("t6_blocked", seen, 0);
        check_eq("t6_busy", busy, 1);
        rdy_mode = 0;
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            @(negedge clk);
            if (add_load_a) seen = 1;
            step();
        end
        check_eq("t6_issued", seen, 1);
        drain("t6_drain2");
        repeat (2) step();
        check_eq("t6_ops_final", ops_done, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
